// File: rtl/fc_layer_engine_pkg.sv
// Shared widths and FSM encoding for the fully-connected layer engines.
package fc_layer_engine_pkg;
    localparam int VEC_LEN = 128;
    localparam int ELEM_W  = 16;
    localparam int SUM_W   = 31;
    localparam int ADDR_W  = 11;
    localparam int IDX_W   = $clog2(VEC_LEN);

    typedef enum logic [1:0] {
        S_ISSUE = 2'd0,
        S_WAIT  = 2'd1,
        S_CAPT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/fc_layer_engine_postproc.sv
// Combinational rescale, optional ReLU and 16-bit saturation of a MultAdder sum.
module fc_postproc
    import fc_layer_engine_pkg::*;
#(
    parameter int FRAC_BITS = 8,
    parameter int RELU      = 1
) (
    input  logic signed [SUM_W-1:0]  sum,
    output logic signed [ELEM_W-1:0] result,
    output logic                     sat_flag
);

    localparam logic signed [SUM_W-1:0] SAT_HI = SUM_W'(2 ** (ELEM_W - 1) - 1);
    localparam logic signed [SUM_W-1:0] SAT_LO = SUM_W'(-(2 ** (ELEM_W - 1)));

    // Returns {clamped, value}; ReLU zeroing happens before this and is not a clamp.
    function automatic logic [ELEM_W:0] saturate(input logic signed [SUM_W-1:0] v);
        if (v > SAT_HI)
            return {1'b1, SAT_HI[ELEM_W-1:0]};
        else if (v < SAT_LO)
            return {1'b1, SAT_LO[ELEM_W-1:0]};
        else
            return {1'b0, v[ELEM_W-1:0]};
    endfunction

    logic signed [SUM_W-1:0] shifted;

    always_comb begin
        shifted = sum >>> FRAC_BITS;
        if ((RELU != 0) && (shifted < 0))
            shifted = '0;
        {sat_flag, result} = saturate(shifted);
    end

endmodule

// File: rtl/fc_layer_engine.sv
// Fully-connected layer responder: one ROM weight word and one dot product per output neuron.
module fc_layer_engine
    import fc_layer_engine_pkg::*;
#(
    parameter int N_OUT     = 128,
    parameter int ROM_BASE  = 0,
    parameter int FRAC_BITS = 8,
    parameter int RELU      = 1
) (
    input  logic                          clk,
    input  logic                          iRst_n,
    input  logic                          ena,
    input  logic [VEC_LEN*ELEM_W-1:0]     data_from_rom,
    input  logic [VEC_LEN*ELEM_W-1:0]     data_from_ram,
    input  logic signed [SUM_W-1:0]       data_from_MultAdder,
    input  logic                          overflow_from_MultAdder,
    output logic                          overflow,
    output logic                          done,
    output logic [ADDR_W-1:0]             addr_to_rom,
    output logic [VEC_LEN*ELEM_W-1:0]     opr1_to_MultAdder,
    output logic [VEC_LEN*ELEM_W-1:0]     opr2_to_MultAdder,
    output logic [N_OUT*ELEM_W-1:0]       data_to_ram
);

    state_t                    state, state_d;
    logic [IDX_W-1:0]          idx;
    logic                      last;
    logic signed [ELEM_W-1:0]  pp_result;
    logic                      pp_sat;

    assign opr1_to_MultAdder = data_from_rom;
    assign opr2_to_MultAdder = data_from_ram;
    assign last              = (idx == IDX_W'(N_OUT - 1));

    fc_postproc #(
        .FRAC_BITS (FRAC_BITS),
        .RELU      (RELU)
    ) u_postproc (
        .sum      (data_from_MultAdder),
        .result   (pp_result),
        .sat_flag (pp_sat)
    );

    always_ff @(posedge clk or negedge iRst_n) begin
        if (!iRst_n)
            state <= S_ISSUE;
        else
            state <= state_d;
    end

    // ena gates every transition except the terminal one, which is absorbing.
    always_comb begin
        state_d = state;
        case (state)
            S_ISSUE: if (ena) state_d = S_WAIT;
            S_WAIT:  if (ena) state_d = S_CAPT;
            S_CAPT:  if (ena) state_d = last ? S_DONE : S_ISSUE;
            S_DONE:  state_d = S_DONE;
            default: state_d = S_ISSUE;
        endcase
    end

    always_ff @(posedge clk or negedge iRst_n) begin
        if (!iRst_n) begin
            idx         <= '0;
            addr_to_rom <= ADDR_W'(ROM_BASE);
            overflow    <= 1'b0;
            done        <= 1'b0;
            data_to_ram <= '0;
        end else begin
            if (state == S_DONE)
                done <= 1'b1;
            if (ena) begin
                case (state)
                    S_ISSUE: addr_to_rom <= ADDR_W'(ROM_BASE) + ADDR_W'(idx);
                    S_CAPT: begin
                        overflow <= overflow | overflow_from_MultAdder | pp_sat;
                        for (int i = 0; i < N_OUT; i++)
                            if (idx == IDX_W'(i))
                                data_to_ram[i*ELEM_W +: ELEM_W] <= pp_result;
                        if (!last)
                            idx <= idx + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fc_layer_engine.sv
// Directed scoreboard bench for fc_layer_engine: two instances (ReLU on / off) share one ROM and MultAdder model.
module tb_fc_layer_engine;
    localparam int NO   = 4;
    localparam int BASE = 16;

    logic              clk = 1'b0;
    logic              iRst_n = 1'b0;
    logic              ena = 1'b0;
    logic [2047:0]     rom_w, ram_w;
    logic signed [30:0] ma_sum;
    logic              ma_ovf;
    logic [10:0]       rom_addr_q;
    int                ri;

    logic              ovf_a, done_a, ovf_b, done_b;
    logic [10:0]       addr_a, addr_b;
    logic [2047:0]     opr1_a, opr2_a, opr1_b, opr2_b;
    logic [NO*16-1:0]  data_a, data_b;

    logic signed [30:0] sum_tab [NO];
    bit   [NO-1:0]      ovf_tab;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] exp_a_q[$], exp_b_q[$];
    bit          eov_a_q[$], eov_b_q[$];
    logic [10:0] addr_q[$];

    always #5 clk = ~clk;

    fc_layer_engine #(.N_OUT(NO), .ROM_BASE(BASE), .FRAC_BITS(8), .RELU(1)) dut_a (
        .clk(clk), .iRst_n(iRst_n), .ena(ena),
        .data_from_rom(rom_w), .data_from_ram(ram_w),
        .data_from_MultAdder(ma_sum), .overflow_from_MultAdder(ma_ovf),
        .overflow(ovf_a), .done(done_a), .addr_to_rom(addr_a),
        .opr1_to_MultAdder(opr1_a), .opr2_to_MultAdder(opr2_a), .data_to_ram(data_a)
    );

    fc_layer_engine #(.N_OUT(NO), .ROM_BASE(BASE), .FRAC_BITS(8), .RELU(0)) dut_b (
        .clk(clk), .iRst_n(iRst_n), .ena(ena),
        .data_from_rom(rom_w), .data_from_ram(ram_w),
        .data_from_MultAdder(ma_sum), .overflow_from_MultAdder(ma_ovf),
        .overflow(ovf_b), .done(done_b), .addr_to_rom(addr_b),
        .opr1_to_MultAdder(opr1_b), .opr2_to_MultAdder(opr2_b), .data_to_ram(data_b)
    );

    // Synchronous ROM with one cycle of read latency; the MultAdder answers per fetched word.
    always_ff @(posedge clk) rom_addr_q <= addr_a;

    always_comb begin
        ri     = int'(rom_addr_q) - BASE;
        ma_sum = '0;
        ma_ovf = 1'b0;
        if (ri >= 0 && ri < NO) begin
            ma_sum = sum_tab[ri];
            ma_ovf = ovf_tab[ri];
        end
        rom_w = {128{{5'b0, rom_addr_q}}};
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_pp(input logic signed [30:0] s, input bit relu, output bit sat);
        longint t;
        t   = longint'(s) >>> 8;
        sat = 1'b0;
        if (relu && t < 0) t = 0;
        if (t > 32767) begin t = 32767; sat = 1'b1; end
        else if (t < -32768) begin t = -32768; sat = 1'b1; end
        return t[15:0];
    endfunction

    task automatic do_reset();
        iRst_n = 1'b0;
        ena    = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_done", {63'b0, done_a}, 64'd0);
        chk("rst_ovf", {63'b0, ovf_a}, 64'd0);
        chk("rst_data_a", data_a, 64'd0);
        chk("rst_data_b", data_b, 64'd0);
        chk("rst_addr", {53'b0, addr_a}, 64'd16);
        iRst_n = 1'b1;
        ena    = 1'b1;
    endtask

    task automatic run_layer(input int gap, input bit rst_mid);
        logic [63:0] vec_a, vec_b;
        bit sat, acc_a, acc_b, en_now;
        logic [15:0] r;
        int edges, en_edges, done_edge, k;
        vec_a = '0; vec_b = '0; acc_a = 0; acc_b = 0;
        for (int i = 0; i < NO; i++) begin
            r = ref_pp(sum_tab[i], 1'b1, sat);
            acc_a |= sat | ovf_tab[i];
            exp_a_q.push_back(r); eov_a_q.push_back(acc_a); vec_a[i*16 +: 16] = r;
            r = ref_pp(sum_tab[i], 1'b0, sat);
            acc_b |= sat | ovf_tab[i];
            exp_b_q.push_back(r); eov_b_q.push_back(acc_b); vec_b[i*16 +: 16] = r;
            addr_q.push_back(11'(BASE + i));
        end
        edges = 0; en_edges = 0; done_edge = -1;
        while (edges < 100 && done_edge < 0) begin
            en_now = ena;
            @(posedge clk);
            edges++;
            if (en_now) en_edges++;
            @(negedge clk);
            if (en_now && en_edges % 3 == 1 && en_edges <= 3*NO - 2)
                chk("addr_seq", {53'b0, addr_a}, {53'b0, addr_q.pop_front()});
            if (en_now && en_edges % 3 == 0 && en_edges <= 3*NO) begin
                k = en_edges / 3 - 1;
                chk($sformatf("slot%0d_a", k), {48'b0, data_a[k*16 +: 16]}, {48'b0, exp_a_q.pop_front()});
                chk($sformatf("slot%0d_b", k), {48'b0, data_b[k*16 +: 16]}, {48'b0, exp_b_q.pop_front()});
                chk($sformatf("ovf%0d_a", k), {63'b0, ovf_a}, {63'b0, eov_a_q.pop_front()});
                chk($sformatf("ovf%0d_b", k), {63'b0, ovf_b}, {63'b0, eov_b_q.pop_front()});
            end
            if (gap > 0 && edges == 7) begin
                chk("freeze_addr", {53'b0, addr_a}, 64'd17);
                chk("freeze_data", data_a, vec_a & 64'hFFFF);
            end
            if (rst_mid && edges == 8) begin
                #2 iRst_n = 1'b0;
                #1;
                chk("arst_data", data_a, 64'd0);
                chk("arst_addr", {53'b0, addr_a}, 64'd16);
                chk("arst_done", {63'b0, done_a}, 64'd0);
                exp_a_q.delete(); exp_b_q.delete(); eov_a_q.delete(); eov_b_q.delete(); addr_q.delete();
                return;
            end
            if (done_a) done_edge = edges;
            ena = !(gap > 0 && edges >= 4 && edges < 4 + gap);
        end
        chk("done_edge", 64'(done_edge), 64'(3*NO + 1 + gap));
        chk("final_a", data_a, vec_a);
        chk("final_b", data_b, vec_b);
        chk("final_ovf_a", {63'b0, ovf_a}, {63'b0, acc_a});
        n_cmp++;
        assert (opr1_a === rom_w && opr2_a === ram_w) else begin
            n_bad++;
            $error("FAIL opr_pass: observed %h/%h expected %h/%h", opr1_a[31:0], opr2_a[31:0], rom_w[31:0], ram_w[31:0]);
        end
        ena = 1'b0;
        repeat (2) @(negedge clk);
        chk("done_hold", {63'b0, done_a}, 64'd1);
        chk("data_hold", data_a, vec_a);
        ena = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ram_w[i*32 +: 32] = $urandom;
        ovf_tab = '0;

        // Baseline: sums 0x100*(i+1) -> results 1..4
        for (int i = 0; i < NO; i++) sum_tab[i] = 31'((i + 1) * 256);
        do_reset();
        run_layer(0, 1'b0);

        // Negative and saturating sums
        sum_tab[0] = -31'sd512;
        sum_tab[1] = 31'h3FFFFFFF;
        sum_tab[2] = 31'sd256;
        sum_tab[3] = 31'sd1280;
        do_reset();
        run_layer(0, 1'b0);

        // MultAdder overflow raised only for neuron 2
        for (int i = 0; i < NO; i++) sum_tab[i] = 31'((i + 1) * 256);
        ovf_tab = 4'b0100;
        do_reset();
        run_layer(0, 1'b0);
        ovf_tab = '0;

        // Five frozen cycles in neuron 1's wait state
        do_reset();
        run_layer(5, 1'b0);

        // Asynchronous reset during neuron 2's capture, then a clean rerun
        do_reset();
        run_layer(0, 1'b1);
        do_reset();
        run_layer(0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
